ber_lane_array: RTL and testbench



---
 rtl/ber_lane_array.sv | 189 ++++++++++++++++++
 tb/tb_ber_lane_array.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ber_lane_array.sv
// rtl/ber_lane_array.sv - multi-channel PRBS7/PRBS15 BER generator and checker
// Per channel: LFSR transmitter, self-synchronising checker with HUNT/LOCK, saturating counters.
module ber_lane_array #(
    parameter int NCH      = 4,
    parameter int W        = 2,
    parameter int RCW      = 58,
    parameter int ECW      = 64,
    parameter int LOCK_CNT = 16,
    parameter int LOSS_CNT = 8,
    parameter int SW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLR,
    input  logic             MODE,
    input  logic [NCH-1:0]   ERR_INJ,
    output logic [NCH*W-1:0] DOUT,
    input  logic [NCH*W-1:0] DIN,
    input  logic [SW-1:0]    SEL,
    output logic [NCH-1:0]   LOCKED,
    output logic [RCW-1:0]   RECV_CNT,
    output logic [ECW-1:0]   ERR_CNT
);

    localparam int EW  = $clog2(W + 1);
    localparam int CW  = $clog2(LOCK_CNT + 1);
    localparam int LW  = $clog2(LOSS_CNT + 1);
    localparam int SWE = SW + 1;
    localparam int RSW = RCW + 1;
    localparam int ESW = ECW + 1;

    typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

    // Register always shifts all 15 bits so a PRBS7->PRBS15 switch keeps real history.
    function automatic logic pred_bit(input logic [14:0] s, input logic m);
        return m ? (s[14] ^ s[13]) : (s[6] ^ s[5]);
    endfunction

    logic                 mode_q;
    logic                 mode_chg;
    logic [NCH*RCW-1:0]   recv_flat;
    logic [NCH*ECW-1:0]   err_flat;
    logic [RCW-1:0]       recv_mux;
    logic [ECW-1:0]       err_mux;
    logic [SWE-1:0]       sel_ext;

    always_ff @(posedge CLK) begin
        mode_q <= MODE;
    end

    assign mode_chg = (MODE != mode_q);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [14:0]    tx_s;
        logic [14:0]    tx_nxt;
        logic [W-1:0]   tx_word;
        logic [W-1:0]   dout_q;
        logic [14:0]    chk_s;
        logic [14:0]    chk_nxt;
        logic [W-1:0]   mism;
        logic [EW-1:0]  e;
        logic           nz;
        logic           hunt;
        state_t         state;
        logic [CW-1:0]  clean_cnt;
        logic [LW-1:0]  loss_cnt;
        logic [RCW-1:0] recv_q;
        logic [ECW-1:0] err_q;
        logic [RSW-1:0] recv_sum;
        logic [ESW-1:0] err_sum;

        always_comb begin
            tx_nxt  = mode_chg ? 15'h7FFF : tx_s;
            tx_word = '0;
            for (int i = W - 1; i >= 0; i--) begin
                tx_word[i] = pred_bit(tx_nxt, MODE);
                tx_nxt     = {tx_nxt[13:0], tx_word[i]};
            end
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                tx_s   <= 15'h7FFF;
                dout_q <= '0;
            end else begin
                tx_s   <= tx_nxt;
                dout_q <= tx_word ^ (W'(ERR_INJ[c]) << (W - 1));
            end
        end

        assign DOUT[c*W +: W] = dout_q;

        // HUNT shifts received bits in; LOCK free-runs on its own prediction.
        always_comb begin
            logic p;
            p       = 1'b0;
            hunt    = (state == HUNT) || mode_chg;
            nz      = MODE ? (|chk_s) : (|chk_s[6:0]);
            chk_nxt = chk_s;
            mism    = '0;
            e       = '0;
            for (int i = W - 1; i >= 0; i--) begin
                p       = pred_bit(chk_nxt, MODE);
                mism[i] = p ^ DIN[c*W + i];
                chk_nxt = {chk_nxt[13:0], hunt ? DIN[c*W + i] : p};
                e       = e + EW'(mism[i]);
            end
        end

        assign recv_sum = {1'b0, recv_q} + RSW'(W);
        assign err_sum  = {1'b0, err_q} + ESW'(e);

        always_ff @(posedge CLK) begin
            if (RST) begin
                state     <= HUNT;
                chk_s     <= '0;
                clean_cnt <= '0;
                loss_cnt  <= '0;
                recv_q    <= '0;
                err_q     <= '0;
            end else begin
                chk_s <= chk_nxt;
                if (mode_chg) begin
                    state     <= HUNT;
                    clean_cnt <= '0;
                    loss_cnt  <= '0;
                end else if (state == HUNT) begin
                    if (e == '0 && nz) begin
                        if (clean_cnt == CW'(LOCK_CNT - 1)) begin
                            state     <= LOCK;
                            clean_cnt <= '0;
                        end else begin
                            clean_cnt <= clean_cnt + 1'b1;
                        end
                    end else begin
                        clean_cnt <= '0;
                    end
                end else begin
                    if (e != '0) begin
                        if (loss_cnt == LW'(LOSS_CNT - 1)) begin
                            state    <= HUNT;
                            loss_cnt <= '0;
                        end else begin
                            loss_cnt <= loss_cnt + 1'b1;
                        end
                    end else begin
                        loss_cnt <= '0;
                    end
                end

                if (CLR) begin
                    recv_q <= '0;
                    err_q  <= '0;
                end else if (state == LOCK && !mode_chg) begin
                    recv_q <= recv_sum[RCW] ? '1 : recv_sum[RCW-1:0];
                    err_q  <= err_sum[ECW] ? '1 : err_sum[ECW-1:0];
                end
            end
        end

        assign LOCKED[c]                = (state == LOCK);
        assign recv_flat[c*RCW +: RCW]  = recv_q;
        assign err_flat[c*ECW +: ECW]   = err_q;
    end

    assign sel_ext = {1'b0, SEL};

    always_comb begin
        recv_mux = '0;
        err_mux  = '0;
        for (int c = 0; c < NCH; c++) begin
            if (sel_ext == SWE'(c)) begin
                recv_mux = recv_flat[c*RCW +: RCW];
                err_mux  = err_flat[c*ECW +: ECW];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            RECV_CNT <= '0;
            ERR_CNT  <= '0;
        end else begin
            RECV_CNT <= recv_mux;
            ERR_CNT  <= err_mux;
        end
    end

endmodule

// File: tb/tb_ber_lane_array.sv
// tb/tb_ber_lane_array.sv - bench for ber_lane_array against a bit-history reference model
module tb_ber_lane_array;

    localparam int NCH      = 4;
    localparam int W        = 2;
    localparam int LOCK_CNT = 16;
    localparam int LOSS_CNT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, clr, mode;
    logic [NCH-1:0]   inj;
    logic [NCH*W-1:0] din;
    logic [1:0]       sel;
    logic [NCH*W-1:0] dout, dout_s;
    logic [NCH-1:0]   locked, locked_s;
    logic [57:0]      recv;
    logic [63:0]      err;
    logic [3:0]       recv_s, err_s;

    ber_lane_array u_dut (
        .CLK(clk), .RST(rst), .CLR(clr), .MODE(mode), .ERR_INJ(inj),
        .DOUT(dout), .DIN(din), .SEL(sel), .LOCKED(locked),
        .RECV_CNT(recv), .ERR_CNT(err)
    );

    ber_lane_array #(.RCW(4), .ECW(4)) u_sat (
        .CLK(clk), .RST(rst), .CLR(clr), .MODE(mode), .ERR_INJ(inj),
        .DOUT(dout_s), .DIN(din), .SEL(sel), .LOCKED(locked_s),
        .RECV_CNT(recv_s), .ERR_CNT(err_s)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: transmitted/received bit histories, newest at the back.
    bit                tx_h[NCH][$];
    bit                rx_h[NCH][$];
    bit                st[NCH];
    int                clean[NCH], loss[NCH];
    longint unsigned   rc[NCH], ec[NCH];
    logic [NCH*W-1:0]  m_dout;
    bit                m_mode;
    longint unsigned   m_rrd, m_erd;

    logic [NCH-1:0]    inv_mask;
    logic [NCH*W-1:0]  flip;
    bit                din_zero;

    function automatic longint unsigned satv(input longint unsigned v, input int w);
        longint unsigned mx;
        mx = (64'd1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_edge();
        int n, sz, e;
        bit b, p, nz, hunt, was_lock, mchg;
        logic [NCH*W-1:0] nd;
        logic [W-1:0] wd;
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                tx_h[c].delete();
                rx_h[c].delete();
                for (int k = 0; k < 15; k++) begin
                    tx_h[c].push_back(1'b1);
                    rx_h[c].push_back(1'b0);
                end
                st[c] = 0; clean[c] = 0; loss[c] = 0; rc[c] = 0; ec[c] = 0;
            end
            m_dout = '0; m_mode = mode; m_rrd = 0; m_erd = 0;
            return;
        end
        mchg   = (mode != m_mode);
        m_mode = mode;
        n      = mode ? 15 : 7;
        m_rrd  = rc[sel];
        m_erd  = ec[sel];
        nd     = '0;
        for (int c = 0; c < NCH; c++) begin
            if (mchg) begin
                tx_h[c].delete();
                for (int k = 0; k < 15; k++) tx_h[c].push_back(1'b1);
            end
            wd = '0;
            for (int i = W - 1; i >= 0; i--) begin
                sz = tx_h[c].size();
                b  = tx_h[c][sz-n] ^ tx_h[c][sz-n+1];
                tx_h[c].push_back(b);
                void'(tx_h[c].pop_front());
                wd[i] = b;
            end
            if (inj[c]) wd[W-1] = ~wd[W-1];
            nd[c*W +: W] = wd;

            sz = rx_h[c].size();
            nz = 0;
            for (int j = 1; j <= n; j++) if (rx_h[c][sz-j]) nz = 1;
            hunt = !st[c] || mchg;
            e = 0;
            for (int i = W - 1; i >= 0; i--) begin
                sz = rx_h[c].size();
                p  = rx_h[c][sz-n] ^ rx_h[c][sz-n+1];
                if (p != din[c*W + i]) e++;
                rx_h[c].push_back(hunt ? din[c*W + i] : p);
                void'(rx_h[c].pop_front());
            end
            was_lock = st[c] && !mchg;
            if (mchg) begin
                st[c] = 0; clean[c] = 0; loss[c] = 0;
            end else if (!st[c]) begin
                if (e == 0 && nz) begin
                    clean[c]++;
                    if (clean[c] == LOCK_CNT) begin st[c] = 1; clean[c] = 0; end
                end else clean[c] = 0;
            end else begin
                if (e != 0) begin
                    loss[c]++;
                    if (loss[c] == LOSS_CNT) begin st[c] = 0; loss[c] = 0; end
                end else loss[c] = 0;
            end
            if (clr) begin rc[c] = 0; ec[c] = 0; end
            else if (was_lock) begin rc[c] += W; ec[c] += e; end
        end
        m_dout = nd;
    endtask

    task automatic step();
        logic [NCH*W-1:0] w;
        logic [NCH-1:0] ml;
        @(negedge clk);
        w = din_zero ? '0 : m_dout;
        for (int c = 0; c < NCH; c++) if (inv_mask[c]) w[c*W +: W] = ~w[c*W +: W];
        din = w ^ flip;
        model_edge();
        @(posedge clk);
        #1;
        for (int c = 0; c < NCH; c++) ml[c] = st[c];
        chk("dout", dout, m_dout);
        chk("locked", locked, ml);
        chk("recv", recv, satv(m_rrd, 58));
        chk("err", err, m_erd);
        chk("s_locked", locked_s, ml);
        chk("s_recv", recv_s, satv(m_rrd, 4));
        chk("s_err", err_s, satv(m_erd, 4));
    endtask

    initial begin
        rst = 1; clr = 0; mode = 0; inj = '0; sel = 0; din = '0;
        inv_mask = '0; flip = '0; din_zero = 0;
        repeat (3) step();
        rst = 0;
        for (int k = 1; k <= 4 + LOCK_CNT + 2; k++) step();
        chk("lock_time", locked, 4'hF);

        clr = 1; step(); clr = 0;
        for (int k = 0; k < 1001; k++) begin
            sel = (k == 1000) ? 2'd0 : 2'($urandom_range(0, 3));
            step();
        end
        chk("recv_1000", recv, 2000);
        chk("err_1000", err, 0);
        chk("sat_hold", recv_s, 15);

        clr = 1; sel = 0; step(); clr = 0;
        step(); chk("sat_clr", recv_s, 0);
        step(); chk("sat_resume", recv_s, 2);

        clr = 1; step(); clr = 0;
        inj = 4'b0010; step(); inj = '0;
        sel = 1; repeat (5) step();
        chk("inj_err1", err, 1);
        chk("inj_lock", locked, 4'hF);
        for (int s = 0; s < NCH; s++) begin
            if (s != 1) begin
                sel = 2'(s); step();
                chk("inj_other", err, 0);
            end
        end

        sel = 2; clr = 1; step(); clr = 0;
        inv_mask = 4'b0100;
        repeat (LOSS_CNT - 1) step();
        chk("inv_lock7", locked[2], 1);
        step();
        chk("inv_unlock", locked[2], 0);
        step();
        chk("inv_err16", err, 16);
        chk("inv_sat_err", err_s, 15);
        inv_mask = '0;
        repeat (40) step();
        chk("relock", locked, 4'hF);

        repeat (600) begin
            sel  = 2'($urandom_range(0, 3));
            clr  = ($urandom_range(0, 49) == 0);
            for (int c = 0; c < NCH; c++) inj[c] = ($urandom_range(0, 19) == 0);
            for (int b = 0; b < NCH*W; b++) flip[b] = ($urandom_range(0, 99) == 0);
            step();
        end
        clr = 0; inj = '0; flip = '0;
        repeat (40) step();
        chk("rand_relock", locked, 4'hF);

        mode = 1; step();
        chk("mode_unlock", locked, 0);
        repeat (200) step();
        chk("mode_relock", locked, 4'hF);

        mode = 0; rst = 1; step(); rst = 0;
        din_zero = 1;
        repeat (500) step();
        chk("zero_lock", locked, 0);
        chk("zero_recv", recv, 0);
        chk("zero_err", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
